// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule helpers: forward S-box, GF(2^8) xtime and its
// inverse, rcon endpoints and the scheduler state encoding.
package aes_key_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} ks_state_t;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] RCON_FINAL = 8'h36;
  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Index 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by x^-1 in GF(2^8): fold the polynomial back in when bit 0 is set.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    logic [8:0] t;
    t = x[0] ? ({1'b0, x} ^ 9'h11b) : {1'b0, x};
    return t[8:1];
  endfunction

endpackage

// File: rtl/key_sub_word.sv
// Combinational RotWord followed by SubWord on one 32-bit word.
module key_sub_word
  import aes_key_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  logic [31:0] rot;
  assign rot = {word[23:0], word[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
  end

endmodule

// File: rtl/inv_key_sched.sv
// AES-128 inverse key scheduler: expands the cipher key forward to K10 one
// round per cycle, then walks back toward K0 one key per accepted stepReq.
// Optional feature macro: INV_KEY_REWIND_EN (adds rewind port + K10 shadow).
module inv_key_sched
  import aes_key_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         keyLoad,
  input  logic [127:0] keyIn,
  input  logic         stepReq,
`ifdef INV_KEY_REWIND_EN
  input  logic         rewind,
`endif
  output logic [127:0] roundKey,
  output logic [3:0]   round,
  output logic         keyValid,
  output logic         busy
);

  ks_state_t   state;
  logic [7:0]  rcon;
  logic [31:0] a0, a1, a2, a3;
  logic [31:0] sw_in, sw_out, rc_word;
  logic [127:0] fwd_key, bwd_key;

`ifdef INV_KEY_REWIND_EN
  logic [127:0] k10_shadow;
`endif

  assign {a0, a1, a2, a3} = roundKey;
  assign rc_word = {rcon, 24'h0};

  // One S-box word shared by both directions: forward uses a3, backward
  // needs the recovered previous w3, which is a3^a2.
  assign sw_in = (state == READY) ? (a3 ^ a2) : a3;

  key_sub_word u_sub (
    .word (sw_in),
    .sub  (sw_out)
  );

  // Forward and inverse key-expansion recurrences on the working key.
  always_comb begin
    logic [31:0] f0, f1, f2;
    f0 = a0 ^ sw_out ^ rc_word;
    f1 = a1 ^ f0;
    f2 = a2 ^ f1;
    fwd_key = {f0, f1, f2, a3 ^ f2};
    bwd_key = {a0 ^ sw_out ^ rc_word, a1 ^ a0, a2 ^ a1, a3 ^ a2};
  end

  // Scheduler state, working key and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      roundKey <= '0;
      round    <= '0;
      rcon     <= RCON_INIT;
      keyValid <= 1'b0;
      busy     <= 1'b0;
`ifdef INV_KEY_REWIND_EN
      k10_shadow <= '0;
`endif
    end else if (keyLoad) begin
      state    <= EXPAND;
      roundKey <= keyIn;
      round    <= '0;
      rcon     <= RCON_INIT;
      keyValid <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        EXPAND: begin
          roundKey <= fwd_key;
          round    <= round + 4'd1;
          if (round == LAST_ROUND - 4'd1) begin
            // K10 was just built with rcon 36; keep it for the first step back.
            state    <= READY;
            keyValid <= 1'b1;
            busy     <= 1'b0;
            rcon     <= RCON_FINAL;
`ifdef INV_KEY_REWIND_EN
            k10_shadow <= fwd_key;
`endif
          end else begin
            rcon <= xtime(rcon);
          end
        end
        READY: begin
`ifdef INV_KEY_REWIND_EN
          if (rewind) begin
            roundKey <= k10_shadow;
            round    <= LAST_ROUND;
            rcon     <= RCON_FINAL;
          end else
`endif
          if (stepReq && round != 4'd0) begin
            roundKey <= bwd_key;
            round    <= round - 4'd1;
            rcon     <= inv_xtime(rcon);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_sched.sv
// Directed self-checking bench for inv_key_sched (FIPS-197 key vectors).
module tb_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         keyLoad = 1'b0;
  logic [127:0] keyIn = '0;
  logic         stepReq = 1'b0;
`ifdef INV_KEY_REWIND_EN
  logic         rewind = 1'b0;
`endif
  logic [127:0] roundKey;
  logic [3:0]   round;
  logic         keyValid;
  logic         busy;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z9  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  inv_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .keyLoad  (keyLoad),
    .keyIn    (keyIn),
    .stepReq  (stepReq),
`ifdef INV_KEY_REWIND_EN
    .rewind   (rewind),
`endif
    .roundKey (roundKey),
    .round    (round),
    .keyValid (keyValid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [3:0] r, input logic v, input logic b);
    chk({tag, ".round"}, {124'h0, round}, {124'h0, r});
    chk({tag, ".keyValid"}, {127'h0, keyValid}, {127'h0, v});
    chk({tag, ".busy"}, {127'h0, busy}, {127'h0, b});
  endtask

  task automatic load(input logic [127:0] k, input logic step);
    keyIn = k; keyLoad = 1'b1; stepReq = step;
    tick();
    keyLoad = 1'b0; stepReq = 1'b0;
  endtask

  initial begin
    // Reset state, and stepReq while idle is ignored.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("reset.key", roundKey, '0);
    chk_status("reset", 4'd0, 1'b0, 1'b0);
    stepReq = 1'b1;
    tick(3);
    stepReq = 1'b0;
    chk("idle_step.key", roundKey, '0);
    chk_status("idle_step", 4'd0, 1'b0, 1'b0);

    // Forward expansion: busy for ten cycles, then K10 valid.
    load(K0, 1'b0);
    chk_status("load", 4'd0, 1'b0, 1'b1);
    tick(9);
    chk_status("expand9", 4'd9, 1'b0, 1'b1);
    tick();
    chk("k10.key", roundKey, K10);
    chk_status("k10", 4'd10, 1'b1, 1'b0);

    // Walk down with stepReq held; the eleventh request is ignored.
    stepReq = 1'b1;
    tick();
    chk("k9.key", roundKey, K9);
    chk_status("k9", 4'd9, 1'b1, 1'b0);
    tick(8);
    chk("k1.key", roundKey, K1);
    tick();
    chk("k0.key", roundKey, K0);
    chk_status("k0", 4'd0, 1'b1, 1'b0);
    tick();
    stepReq = 1'b0;
    chk("k0_hold.key", roundKey, K0);
    chk_status("k0_hold", 4'd0, 1'b1, 1'b0);

    // Restart mid-expansion with the zero key.
    load(K0, 1'b0);
    tick(5);
    load('0, 1'b0);
    chk("restart.key", roundKey, '0);
    chk_status("restart", 4'd0, 1'b0, 1'b1);
    tick(10);
    chk("z10.key", roundKey, Z10);
    chk_status("z10", 4'd10, 1'b1, 1'b0);

    // Load and step together in READY: load wins, step dropped.
    load('0, 1'b1);
    chk("load_vs_step.key", roundKey, '0);
    chk_status("load_vs_step", 4'd0, 1'b0, 1'b1);
    tick(10);
    chk("z10b.key", roundKey, Z10);
    stepReq = 1'b1;
    tick();
    chk("z9.key", roundKey, Z9);
    tick(8);
    stepReq = 1'b0;
    chk("z1.key", roundKey, Z1);
    chk_status("z1", 4'd1, 1'b1, 1'b0);

    // Reset mid-expansion, then a clean reload.
    load(K0, 1'b0);
    tick(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.key", roundKey, '0);
    chk_status("midrst", 4'd0, 1'b0, 1'b0);
    load(K0, 1'b0);
    tick(10);
    chk("reload_k10.key", roundKey, K10);
    chk_status("reload_k10", 4'd10, 1'b1, 1'b0);
    stepReq = 1'b1;
    tick();
    stepReq = 1'b0;
    chk("reload_k9.key", roundKey, K9);

`ifdef INV_KEY_REWIND_EN
    // Step to round 3, rewind to K10 (rewind beats stepReq), then step again.
    stepReq = 1'b1;
    tick(6);
    chk_status("pre_rewind", 4'd3, 1'b1, 1'b0);
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    stepReq = 1'b0;
    chk("rewind.key", roundKey, K10);
    chk_status("rewind", 4'd10, 1'b1, 1'b0);
    stepReq = 1'b1;
    tick();
    stepReq = 1'b0;
    chk("rewind_k9.key", roundKey, K9);
    chk_status("rewind_k9", 4'd9, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
